// File: rtl/occ_line_responder.sv
// Occurrence-line responder: queues {addr_k, addr_l, read_num} lookups, fetches the
// BWT occurrence line(s) over an in-order read port and returns them as a tagged pair.
module occ_line_responder #(
    parameter int REQ_DEPTH = 8,
    parameter int ADDR_W    = 42,
    parameter int LINE_W    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr_k,
    input  logic [ADDR_W-1:0] req_addr_l,
    input  logic [8:0]        req_read_num,
    output logic              stall,
    output logic              mem_rd_valid,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ready,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_line_k,
    output logic [LINE_W-1:0] rsp_line_l,
    output logic [8:0]        rsp_read_num,
    input  logic              rsp_ready
);

    localparam int PTR_W = $clog2(REQ_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(REQ_DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_K = 3'd1,
        S_WT_K = 3'd2,
        S_RD_L = 3'd3,
        S_WT_L = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    logic [ADDR_W-1:0] r_fifo_k   [REQ_DEPTH];
    logic [ADDR_W-1:0] r_fifo_l   [REQ_DEPTH];
    logic [8:0]        r_fifo_num [REQ_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    state_t            r_state;
    state_t            w_next;

    logic              r_mem_rd_valid;
    logic [ADDR_W-1:0] r_mem_rd_addr;
    logic              r_rsp_valid;
    logic [LINE_W-1:0] r_rsp_line_k;
    logic [LINE_W-1:0] r_rsp_line_l;
    logic [8:0]        r_rsp_read_num;

    logic              w_push;
    logic              w_pop;
    logic              w_same_line;
    logic [ADDR_W-1:0] w_head_k;
    logic [ADDR_W-1:0] w_head_l;
    logic [8:0]        w_head_num;

    // The head entry remains in the FIFO while in service, so it still counts toward stall.
    assign stall       = (r_count == FULL_CNT);
    assign w_push      = req_valid && !stall;
    assign w_pop       = (r_state == S_OUT) && rsp_ready;
    assign w_head_k    = r_fifo_k[r_rd_ptr];
    assign w_head_l    = r_fifo_l[r_rd_ptr];
    assign w_head_num  = r_fifo_num[r_rd_ptr];
    assign w_same_line = (w_head_k == w_head_l);

    // Request storage write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_k[r_wr_ptr]   <= req_addr_k;
            r_fifo_l[r_wr_ptr]   <= req_addr_l;
            r_fifo_num[r_wr_ptr] <= req_read_num;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sequencer next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_count != CNT_ZERO) w_next = S_RD_K;
                else                     w_next = S_IDLE;
            end
            S_RD_K: begin
                if (mem_rd_ready) w_next = S_WT_K;
                else              w_next = S_RD_K;
            end
            S_WT_K: begin
                if (mem_rsp_valid) begin
                    if (w_same_line) w_next = S_OUT;
                    else             w_next = S_RD_L;
                end else begin
                    w_next = S_WT_K;
                end
            end
            S_RD_L: begin
                if (mem_rd_ready) w_next = S_WT_L;
                else              w_next = S_RD_L;
            end
            S_WT_L: begin
                if (mem_rsp_valid) w_next = S_OUT;
                else               w_next = S_WT_L;
            end
            S_OUT: begin
                if (rsp_ready) w_next = S_IDLE;
                else           w_next = S_OUT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rd_valid <= 1'b0;
            r_mem_rd_addr  <= {ADDR_W{1'b0}};
            r_rsp_valid    <= 1'b0;
            r_rsp_line_k   <= {LINE_W{1'b0}};
            r_rsp_line_l   <= {LINE_W{1'b0}};
            r_rsp_read_num <= 9'd0;
        end else begin
            r_mem_rd_valid <= (w_next == S_RD_K) || (w_next == S_RD_L);
            if (w_next == S_RD_K) begin
                r_mem_rd_addr <= w_head_k;
            end else if (w_next == S_RD_L) begin
                r_mem_rd_addr <= w_head_l;
            end else begin
                r_mem_rd_addr <= {ADDR_W{1'b0}};
            end
            r_rsp_valid <= (w_next == S_OUT);
            if ((w_next == S_OUT) && (r_state != S_OUT)) begin
                r_rsp_read_num <= w_head_num;
            end
            // Responses outside the wait states are strays and must not touch the lines.
            if ((r_state == S_WT_K) && mem_rsp_valid) begin
                r_rsp_line_k <= mem_rsp_data;
                if (w_same_line) begin
                    r_rsp_line_l <= mem_rsp_data;
                end
            end else if ((r_state == S_WT_L) && mem_rsp_valid) begin
                r_rsp_line_l <= mem_rsp_data;
            end
        end
    end

    assign mem_rd_valid = r_mem_rd_valid;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_line_k   = r_rsp_line_k;
    assign rsp_line_l   = r_rsp_line_l;
    assign rsp_read_num = r_rsp_read_num;

endmodule

// File: tb/tb_occ_line_responder.sv
// Directed bench for occ_line_responder with a 1-cycle in-order memory model that
// can hold back responses on demand.
module tb_occ_line_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [41:0]  req_addr_k;
    logic [41:0]  req_addr_l;
    logic [8:0]   req_read_num;
    logic         stall;
    logic         mem_rd_valid;
    logic [41:0]  mem_rd_addr;
    logic         mem_rd_ready;
    logic         mem_rsp_valid = 1'b0;
    logic [511:0] mem_rsp_data  = 512'd0;
    logic         rsp_valid;
    logic [511:0] rsp_line_k;
    logic [511:0] rsp_line_l;
    logic [8:0]   rsp_read_num;
    logic         rsp_ready;

    int checks = 0;
    int errors = 0;

    logic           mem_hold = 1'b0;
    logic [511:0]   pend[$];
    logic [41:0]    rd_log[$];
    int             rd_cnt = 0;

    occ_line_responder #(.REQ_DEPTH(8), .ADDR_W(42), .LINE_W(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr_k   (req_addr_k),
        .req_addr_l   (req_addr_l),
        .req_read_num (req_read_num),
        .stall        (stall),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_ready (mem_rd_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_line_k   (rsp_line_k),
        .rsp_line_l   (rsp_line_l),
        .rsp_read_num (rsp_read_num),
        .rsp_ready    (rsp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mem_data(input logic [41:0] a);
        if (a == 42'h10)      return {64{8'hAA}};
        else if (a == 42'h20) return {64{8'hBB}};
        else                  return {8{a, 22'h15A5A5}};
    endfunction

    // Memory: accepted reads answer one cycle later unless held.
    always @(posedge clk) begin
        if (mem_rd_valid && mem_rd_ready) begin
            pend.push_back(mem_data(mem_rd_addr));
            rd_log.push_back(mem_rd_addr);
            rd_cnt = rd_cnt + 1;
        end
        if (!mem_hold && (pend.size() > 0)) begin
            mem_rsp_valid <= 1'b1;
            mem_rsp_data  <= pend.pop_front();
        end else begin
            mem_rsp_valid <= 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [41:0] k, input logic [41:0] l, input logic [8:0] num);
        req_valid    = 1'b1;
        req_addr_k   = k;
        req_addr_l   = l;
        req_read_num = num;
        tick;
        req_valid    = 1'b0;
    endtask

    // Returns the cycle index (acceptance cycle = 0) at which rsp_valid is first seen.
    task automatic wait_rsp(input string tag, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            tick;
            lat++;
        end
        chk(tag, {511'd0, rsp_valid}, 512'd1);
    endtask

    logic [41:0] ek[9];
    logic [41:0] el[9];
    int lat;
    int n;
    int e;
    int base;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr_k = 42'd0; req_addr_l = 42'd0;
        req_read_num = 9'd0; mem_rd_ready = 1'b1; rsp_ready = 1'b1;
        tick; tick; tick;
        chk("rst_stall", {511'd0, stall}, 512'd0);
        chk("rst_mem_rd_valid", {511'd0, mem_rd_valid}, 512'd0);
        chk("rst_mem_rd_addr", {470'd0, mem_rd_addr}, 512'd0);
        chk("rst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
        chk("rst_line_k", rsp_line_k, 512'd0);
        chk("rst_read_num", {503'd0, rsp_read_num}, 512'd0);
        rst = 1'b0;
        tick;

        // Two-line pair
        base = rd_cnt;
        send(42'h10, 42'h20, 9'd5);
        wait_rsp("t1_timeout", lat);
        chk("t1_latency", 512'(lat), 512'd6);
        chk("t1_line_k", rsp_line_k, {64{8'hAA}});
        chk("t1_line_l", rsp_line_l, {64{8'hBB}});
        chk("t1_read_num", {503'd0, rsp_read_num}, 512'd5);
        tick;
        chk("t1_valid_one_cycle", {511'd0, rsp_valid}, 512'd0);
        chk("t1_read_count", 512'(rd_cnt - base), 512'd2);
        chk("t1_read0_addr", {470'd0, rd_log[base]}, 512'h10);
        chk("t1_read1_addr", {470'd0, rd_log[base+1]}, 512'h20);

        // Same-line pair
        base = rd_cnt;
        send(42'h40, 42'h40, 9'd9);
        wait_rsp("t2_timeout", lat);
        chk("t2_latency", 512'(lat), 512'd4);
        chk("t2_line_k", rsp_line_k, mem_data(42'h40));
        chk("t2_line_l", rsp_line_l, mem_data(42'h40));
        chk("t2_read_num", {503'd0, rsp_read_num}, 512'd9);
        tick;
        chk("t2_read_count", 512'(rd_cnt - base), 512'd1);

        // Fill to stall, hold a 9th request, then drain in order
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ek[i] = 42'h1000 + 42'(i * 32);
            el[i] = ek[i] + 42'h10;
            req_valid = 1'b1; req_addr_k = ek[i]; req_addr_l = el[i]; req_read_num = 9'(i);
            tick;
            chk($sformatf("t3_stall_after_push%0d", i), {511'd0, stall}, (i == 7) ? 512'd1 : 512'd0);
        end
        ek[8] = 42'h2000; el[8] = 42'h2010;
        req_addr_k = ek[8]; req_addr_l = el[8]; req_read_num = 9'd8;
        wait_rsp("t3_first_timeout", lat);
        chk("t3_first_num", {503'd0, rsp_read_num}, 512'd0);
        chk("t3_first_line_k", rsp_line_k, mem_data(ek[0]));
        chk("t3_first_line_l", rsp_line_l, mem_data(el[0]));
        chk("t3_still_stalled", {511'd0, stall}, 512'd1);
        rsp_ready = 1'b1;
        tick;
        chk("t3_stall_drop", {511'd0, stall}, 512'd0);
        chk("t3_valid_after_pop", {511'd0, rsp_valid}, 512'd0);
        tick;
        req_valid = 1'b0;
        chk("t3_ninth_accepted", {511'd0, stall}, 512'd1);
        e = 1; n = 0;
        while (e <= 8 && n < 400) begin
            if (rsp_valid) begin
                chk($sformatf("t3_num%0d", e), {503'd0, rsp_read_num}, 512'(e));
                chk($sformatf("t3_line_k%0d", e), rsp_line_k, mem_data(ek[e]));
                chk($sformatf("t3_line_l%0d", e), rsp_line_l, mem_data(el[e]));
                e++;
            end
            tick;
            n++;
        end
        chk("t3_all_drained", 512'(e), 512'd9);

        // Memory and response backpressure
        mem_rd_ready = 1'b0;
        send(42'h200, 42'h300, 9'h1AB);
        n = 0;
        while (!mem_rd_valid && n < 20) begin
            tick;
            n++;
        end
        chk("t4_rd_valid_seen", {511'd0, mem_rd_valid}, 512'd1);
        base = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t4_rd_valid_hold", {511'd0, mem_rd_valid}, 512'd1);
            chk("t4_rd_addr_hold", {470'd0, mem_rd_addr}, 512'h200);
        end
        mem_rd_ready = 1'b1;
        rsp_ready = 1'b0;
        wait_rsp("t4_timeout", lat);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t4_rsp_hold_valid", {511'd0, rsp_valid}, 512'd1);
            chk("t4_rsp_hold_k", rsp_line_k, mem_data(42'h200));
            chk("t4_rsp_hold_l", rsp_line_l, mem_data(42'h300));
            chk("t4_rsp_hold_num", {503'd0, rsp_read_num}, 512'h1AB);
        end
        rsp_ready = 1'b1;
        tick;
        chk("t4_valid_drop", {511'd0, rsp_valid}, 512'd0);
        chk("t4_read_count", 512'(rd_cnt - base), 512'd2);
        chk("t4_read_order", {470'd0, rd_log[base+1]}, 512'h300);

        // Reset while waiting on the l line with three requests queued
        send(42'h600, 42'h610, 9'd1);
        send(42'h620, 42'h630, 9'd2);
        send(42'h640, 42'h650, 9'd3);
        n = 0;
        while (!(mem_rd_valid && mem_rd_addr == 42'h610) && n < 40) begin
            tick;
            n++;
        end
        chk("t5_rd_l_seen", {470'd0, mem_rd_addr}, 512'h610);
        mem_hold = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        chk("t5_rst_stall", {511'd0, stall}, 512'd0);
        chk("t5_rst_rd_valid", {511'd0, mem_rd_valid}, 512'd0);
        chk("t5_rst_rd_addr", {470'd0, mem_rd_addr}, 512'd0);
        chk("t5_rst_rsp_valid", {511'd0, rsp_valid}, 512'd0);
        chk("t5_rst_line_k", rsp_line_k, 512'd0);
        chk("t5_rst_line_l", rsp_line_l, 512'd0);
        chk("t5_rst_num", {503'd0, rsp_read_num}, 512'd0);
        rst = 1'b0;
        mem_hold = 1'b0;
        tick; tick; tick;
        chk("t5_late_rsp_valid", {511'd0, rsp_valid}, 512'd0);
        chk("t5_late_line_k", rsp_line_k, 512'd0);
        chk("t5_late_line_l", rsp_line_l, 512'd0);
        chk("t5_idle_rd_valid", {511'd0, mem_rd_valid}, 512'd0);
        send(42'h700, 42'h700, 9'h33);
        wait_rsp("t5_timeout", lat);
        chk("t5_new_latency", 512'(lat), 512'd4);
        chk("t5_new_line_k", rsp_line_k, mem_data(42'h700));
        chk("t5_new_line_l", rsp_line_l, mem_data(42'h700));
        chk("t5_new_num", {503'd0, rsp_read_num}, 512'h33);
        tick;

        // Simultaneous push and pop at count 7, across pointer wrap
        rsp_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ek[i] = 42'h800 + 42'(i * 32);
            el[i] = (i % 2 == 1) ? ek[i] : ek[i] + 42'h10;
            send(ek[i], el[i], 9'(9'h40 + i));
        end
        chk("t6_count7_stall", {511'd0, stall}, 512'd0);
        wait_rsp("t6_head_timeout", lat);
        chk("t6_head_num", {503'd0, rsp_read_num}, 512'h40);
        ek[7] = 42'h900; el[7] = 42'h910;
        req_valid = 1'b1; req_addr_k = ek[7]; req_addr_l = el[7]; req_read_num = 9'h47;
        rsp_ready = 1'b1;
        tick;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("t6_pushpop_stall", {511'd0, stall}, 512'd0);
        chk("t6_pushpop_valid", {511'd0, rsp_valid}, 512'd0);
        ek[8] = 42'h920; el[8] = 42'h920;
        send(ek[8], el[8], 9'h48);
        chk("t6_full_again", {511'd0, stall}, 512'd1);
        rsp_ready = 1'b1;
        e = 1; n = 0;
        while (e <= 8 && n < 400) begin
            if (rsp_valid) begin
                chk($sformatf("t6_num%0d", e), {503'd0, rsp_read_num}, 512'(9'h40 + e));
                chk($sformatf("t6_line_k%0d", e), rsp_line_k, mem_data(ek[e]));
                chk($sformatf("t6_line_l%0d", e), rsp_line_l, mem_data(el[e]));
                e++;
            end
            tick;
            n++;
        end
        chk("t6_all_drained", 512'(e), 512'd9);
        chk("t6_empty_stall", {511'd0, stall}, 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
